// File: rtl/sump_cmd_decoder_pkg.sv
// sump_pkg: shared definitions for the SUMP command decoder.
//   - opcode constants for short (bit 7 clear) and long (bit 7 set) commands
//   - FSM state enumeration
//   - bit positions of the fields inside the flags register
//   - helper recognising the trigger-write opcode block 0xC0-0xCF
package sump_pkg;

  localparam logic [7:0] OP_RESET      = 8'h00;
  localparam logic [7:0] OP_RUN        = 8'h01;
  localparam logic [7:0] OP_ID         = 8'h02;
  localparam logic [7:0] OP_META       = 8'h04;
  localparam logic [7:0] OP_RLE_FINISH = 8'h05;
  localparam logic [7:0] OP_DIVIDER    = 8'h80;
  localparam logic [7:0] OP_COUNT      = 8'h81;
  localparam logic [7:0] OP_FLAGS      = 8'h82;
  localparam logic [7:0] OP_TRIG_BASE  = 8'hC0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ARG  = 1'b1
  } state_e;

  // Flags register field positions.
  localparam int FLAG_DEMUX     = 0;
  localparam int FLAG_GROUP_LO  = 2;
  localparam int FLAG_GROUP_HI  = 5;
  localparam int FLAG_RLE       = 8;
  localparam int FLAG_TESTMODE  = 11;

  // True for the sixteen trigger-write opcodes 0xC0-0xCF.
  function automatic logic is_trig_op(input logic [7:0] op);
    return (op[7:4] == OP_TRIG_BASE[7:4]);
  endfunction

endpackage

// File: rtl/sump_cmd_decoder.sv
// sump_cmd_decoder: assembles SUMP short and long commands from UART bytes.
// Ports:
//   clock, reset_n            core clock, async active-low reset
//   rx_data[7:0], rx_valid    received byte and its one-cycle strobe
//   cmd_reset/run/id/meta/rle_finish   one-cycle short-command strobes
//   divider, read_count, delay_count, flags   configuration registers
//   trig_wr, trig_stage, trig_reg, trig_data  trigger-stage write port
// Long commands are an opcode followed by four argument bytes, little-endian.
// A long command left idle for TIMEOUT cycles is discarded.
module sump_cmd_decoder
  import sump_pkg::*;
#(
  parameter int TIMEOUT = 65535
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        cmd_reset,
  output logic        cmd_run,
  output logic        cmd_id,
  output logic        cmd_meta,
  output logic        cmd_rle_finish,
  output logic [23:0] divider,
  output logic [15:0] read_count,
  output logic [15:0] delay_count,
  output logic [31:0] flags,
  output logic        trig_wr,
  output logic [1:0]  trig_stage,
  output logic [1:0]  trig_reg,
  output logic [31:0] trig_data
);

  localparam int              TW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   TLOAD = TW'(TIMEOUT);

  state_e        state_q, state_d;
  logic [7:0]    opcode_q, opcode_d;
  logic [31:0]   arg_q, arg_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          expired_s;

  logic          cmd_reset_q, cmd_reset_d;
  logic          cmd_run_q, cmd_run_d;
  logic          cmd_id_q, cmd_id_d;
  logic          cmd_meta_q, cmd_meta_d;
  logic          cmd_rle_q, cmd_rle_d;
  logic [23:0]   divider_q, divider_d;
  logic [15:0]   read_count_q, read_count_d;
  logic [15:0]   delay_count_q, delay_count_d;
  logic [31:0]   flags_q, flags_d;
  logic          trig_wr_q, trig_wr_d;
  logic [1:0]    trig_stage_q, trig_stage_d;
  logic [1:0]    trig_reg_q, trig_reg_d;
  logic [31:0]   trig_data_q, trig_data_d;

  // Next-state and output decode for the IDLE/ARG command assembler.
  always_comb begin
    state_d       = state_q;
    opcode_d      = opcode_q;
    arg_d         = arg_q;
    cnt_d         = cnt_q;
    timer_d       = timer_q;
    cmd_reset_d   = 1'b0;
    cmd_run_d     = 1'b0;
    cmd_id_d      = 1'b0;
    cmd_meta_d    = 1'b0;
    cmd_rle_d     = 1'b0;
    trig_wr_d     = 1'b0;
    divider_d     = divider_q;
    read_count_d  = read_count_q;
    delay_count_d = delay_count_q;
    flags_d       = flags_q;
    trig_stage_d  = trig_stage_q;
    trig_reg_d    = trig_reg_q;
    trig_data_d   = trig_data_q;

    // A long command whose timer has run out behaves exactly like IDLE, so
    // a byte arriving on the expiry cycle is decoded as a fresh opcode.
    expired_s = (state_q == ST_ARG) && (timer_q == '0);

    if ((state_q == ST_IDLE) || expired_s) begin
      state_d = ST_IDLE;
      if (rx_valid) begin
        if (rx_data[7]) begin
          opcode_d = rx_data;
          cnt_d    = 2'd0;
          timer_d  = TLOAD;
          state_d  = ST_ARG;
        end else begin
          case (rx_data)
            OP_RESET:      cmd_reset_d = 1'b1;
            OP_RUN:        cmd_run_d   = 1'b1;
            OP_ID:         cmd_id_d    = 1'b1;
            OP_META:       cmd_meta_d  = 1'b1;
            OP_RLE_FINISH: cmd_rle_d   = 1'b1;
            default:       ;
          endcase
        end
      end else begin
        timer_d = timer_q;
      end
    end else begin
      if (rx_valid) begin
        arg_d   = {rx_data, arg_q[31:8]};
        cnt_d   = cnt_q + 2'd1;
        timer_d = TLOAD;
        if (cnt_q == 2'd3) begin
          state_d = ST_IDLE;
          case (opcode_q)
            OP_DIVIDER: divider_d = arg_d[23:0];
            OP_COUNT: begin
              read_count_d  = arg_d[15:0];
              delay_count_d = arg_d[31:16];
            end
            OP_FLAGS:   flags_d = arg_d;
            default: begin
              if (is_trig_op(opcode_q)) begin
                trig_wr_d    = 1'b1;
                trig_stage_d = opcode_q[3:2];
                trig_reg_d   = opcode_q[1:0];
                trig_data_d  = arg_d;
              end else begin
                trig_wr_d    = 1'b0;
              end
            end
          endcase
        end else begin
          state_d = ST_ARG;
        end
      end else begin
        // Non-zero here: the zero case was routed to the IDLE branch.
        timer_d = timer_q - TW'(1);
      end
    end
  end

  // State, argument, counters and all registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      opcode_q      <= 8'h00;
      arg_q         <= 32'h0000_0000;
      cnt_q         <= 2'd0;
      timer_q       <= '0;
      cmd_reset_q   <= 1'b0;
      cmd_run_q     <= 1'b0;
      cmd_id_q      <= 1'b0;
      cmd_meta_q    <= 1'b0;
      cmd_rle_q     <= 1'b0;
      trig_wr_q     <= 1'b0;
      divider_q     <= 24'h00_0000;
      read_count_q  <= 16'h0000;
      delay_count_q <= 16'h0000;
      flags_q       <= 32'h0000_0000;
      trig_stage_q  <= 2'd0;
      trig_reg_q    <= 2'd0;
      trig_data_q   <= 32'h0000_0000;
    end else begin
      state_q       <= state_d;
      opcode_q      <= opcode_d;
      arg_q         <= arg_d;
      cnt_q         <= cnt_d;
      timer_q       <= timer_d;
      cmd_reset_q   <= cmd_reset_d;
      cmd_run_q     <= cmd_run_d;
      cmd_id_q      <= cmd_id_d;
      cmd_meta_q    <= cmd_meta_d;
      cmd_rle_q     <= cmd_rle_d;
      trig_wr_q     <= trig_wr_d;
      divider_q     <= divider_d;
      read_count_q  <= read_count_d;
      delay_count_q <= delay_count_d;
      flags_q       <= flags_d;
      trig_stage_q  <= trig_stage_d;
      trig_reg_q    <= trig_reg_d;
      trig_data_q   <= trig_data_d;
    end
  end

  assign cmd_reset      = cmd_reset_q;
  assign cmd_run        = cmd_run_q;
  assign cmd_id         = cmd_id_q;
  assign cmd_meta       = cmd_meta_q;
  assign cmd_rle_finish = cmd_rle_q;
  assign divider        = divider_q;
  assign read_count     = read_count_q;
  assign delay_count    = delay_count_q;
  assign flags          = flags_q;
  assign trig_wr        = trig_wr_q;
  assign trig_stage     = trig_stage_q;
  assign trig_reg       = trig_reg_q;
  assign trig_data      = trig_data_q;

endmodule
